// File: rtl/spike_index_pingpong_buffer.sv
// N-bank frame buffer: parses SOF/EOF frames from a FWFT FIFO into banks
// round-robin and streams each completed bank out over valid/ready.
module spike_index_pingpong_buffer #(
    parameter int IDX_W = 16,
    parameter int ADDR_W = 9,
    parameter int NBANK = 2,
    parameter logic [IDX_W-1:0] SOF_CODE = 16'hF1FA,
    parameter logic [IDX_W-1:0] EOF_CODE = 16'hFAF1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [IDX_W-1:0]  fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic [NBANK-1:0]  bank_full,
    output logic [ADDR_W:0]   frame_len,
    output logic              err_ovf,
    output logic              err_proto,
    input  logic              err_clr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BW = $clog2(NBANK);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A0 = '0;

    typedef enum logic {W_HUNT, W_FILL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [IDX_W-1:0] mem [NBANK][DEPTH];
    logic [ADDR_W:0]  len [NBANK];
    logic [BW-1:0]    wb, rb;
    logic [ADDR_W:0]  wcnt, rptr;

    logic is_sof, is_eof;
    logic pop, close, wr_en, ovf, proto, rel;

    function automatic logic [BW-1:0] nxt(input logic [BW-1:0] p);
        return (p == BW'(NBANK-1)) ? '0 : p + BW'(1);
    endfunction

    assign is_sof = (fifo_dout == SOF_CODE);
    assign is_eof = (fifo_dout == EOF_CODE);
    assign fifo_rd_en = pop;

    always_comb begin
        pop = 1'b0;
        close = 1'b0;
        wr_en = 1'b0;
        ovf = 1'b0;
        proto = 1'b0;
        if (!fifo_empty) begin
            unique case (w_state)
                W_HUNT: pop = !(is_sof && bank_full[wb]);
                W_FILL: begin
                    unique case (1'b1)
                        is_sof: begin
                            close = 1'b1;
                            proto = 1'b1;
                        end
                        is_eof: begin
                            pop = 1'b1;
                            close = 1'b1;
                        end
                        default: begin
                            pop = 1'b1;
                            // wcnt MSB set means the bank is already full
                            ovf = wcnt[ADDR_W];
                            wr_en = !wcnt[ADDR_W];
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rel = 1'b0;
        unique case (r_state)
            R_IDLE:   rel = bank_full[rb] && (len[rb] == '0);
            R_STREAM: rel = out_ready && out_last;
            default:  rel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wb][wcnt[ADDR_W-1:0]] <= fifo_dout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_HUNT;
            wb <= '0;
            wcnt <= '0;
            bank_full <= '0;
            err_ovf <= 1'b0;
            err_proto <= 1'b0;
            for (int i = 0; i < NBANK; i++)
                len[i] <= '0;
        end else begin
            if (w_state == W_HUNT && pop && is_sof) begin
                wcnt <= '0;
                w_state <= W_FILL;
            end
            if (wr_en)
                wcnt <= wcnt + ONE;
            if (close) begin
                len[wb] <= wcnt;
                wb <= nxt(wb);
                w_state <= W_HUNT;
            end
            for (int i = 0; i < NBANK; i++) begin
                if (close && int'(wb) == i)
                    bank_full[i] <= 1'b1;
                if (rel && int'(rb) == i)
                    bank_full[i] <= 1'b0;
            end
            // a new error outranks a simultaneous clear
            if (ovf)
                err_ovf <= 1'b1;
            else if (err_clr)
                err_ovf <= 1'b0;
            if (proto)
                err_proto <= 1'b1;
            else if (err_clr)
                err_proto <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            rb <= '0;
            rptr <= '0;
            frame_len <= '0;
            out_idx <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (r_state)
                R_IDLE: begin
                    if (bank_full[rb]) begin
                        frame_len <= len[rb];
                        if (len[rb] == '0) begin
                            frame_done <= 1'b1;
                            rb <= nxt(rb);
                        end else begin
                            r_state <= R_LOAD;
                        end
                    end
                end
                R_LOAD: begin
                    out_idx <= mem[rb][A0];
                    out_valid <= 1'b1;
                    out_last <= (frame_len == ONE);
                    rptr <= ONE;
                    r_state <= R_STREAM;
                end
                R_STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last <= 1'b0;
                            frame_done <= 1'b1;
                            rb <= nxt(rb);
                            r_state <= R_IDLE;
                        end else begin
                            out_idx <= mem[rb][rptr[ADDR_W-1:0]];
                            out_last <= (rptr + ONE == frame_len);
                            rptr <= rptr + ONE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
